// File: rtl/jk_seq_driver.sv
// J/K excitation driver: queues target Q bits, drives J/K so an external jk_ff
// follows them, and checks the flip-flop's Q feedback against an internal model.
module jk_seq_driver #(
   parameter int DEPTH      = 4,
   parameter int USE_TOGGLE = 0,
   parameter int INIT_CYC   = 1,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   output logic             J,
   output logic             K,
   input  logic             q_fb,
   output logic             drv_valid,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_cnt,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(INIT_CYC + 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t           state;
   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [IW-1:0]    init_cnt;
   logic             qm;
   logic             s1_v, s1_e, s2_v, s2_e;
   logic             push, pop, head;

   assign tgt_ready = (state == RUN) && (count != CW'(DEPTH));
   assign push      = tgt_valid && tgt_ready;
   assign pop       = (state == RUN) && (count != '0);
   assign head      = mem[rd_ptr];
   assign busy      = (state == INIT) || (count != '0) || s1_v || s2_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         mem       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         init_cnt  <= '0;
         qm        <= 1'b0;
         J         <= 1'b0;
         K         <= 1'b1;
         drv_valid <= 1'b0;
         mismatch  <= 1'b0;
         err_cnt   <= '0;
         s1_v      <= 1'b0;
         s1_e      <= 1'b0;
         s2_v      <= 1'b0;
         s2_e      <= 1'b0;
      end else begin
         // Two-stage check pipe: J/K edge, then Q update edge, then compare.
         s2_v <= s1_v;
         s2_e <= s1_e;
         s1_v <= 1'b0;
         s1_e <= 1'b0;
         if (s2_v) begin
            mismatch <= (q_fb != s2_e);
            if ((q_fb != s2_e) && (err_cnt != '1))
               err_cnt <= err_cnt + ERR_W'(1);
         end else begin
            mismatch <= 1'b0;
         end

         if (push) begin
            mem[wr_ptr] <= tgt_bit;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);

         case (state)
            INIT: begin
               J         <= 1'b0;
               K         <= 1'b1;
               drv_valid <= 1'b0;
               if (init_cnt == IW'(INIT_CYC - 1)) begin
                  state <= RUN;
                  s1_v  <= 1'b1;
                  s1_e  <= 1'b0;
               end else begin
                  init_cnt <= init_cnt + IW'(1);
               end
            end
            RUN: begin
               if (pop) begin
                  drv_valid <= 1'b1;
                  qm        <= head;
                  s1_v      <= 1'b1;
                  s1_e      <= head;
                  if (qm != head) begin
                     J <= (USE_TOGGLE != 0) ? 1'b1 : head;
                     K <= (USE_TOGGLE != 0) ? 1'b1 : !head;
                  end else begin
                     J <= 1'b0;
                     K <= 1'b0;
                  end
               end else begin
                  J         <= 1'b0;
                  K         <= 1'b0;
                  drv_valid <= 1'b0;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: three instances (set/reset mode, toggle mode, narrow
// error counter with stuck feedback) checked every cycle against a queue model.
module tb_jk_seq_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tgt_valid = 1'b0;
   logic       tgt_bit = 1'b0;
   logic [2:0] rdy, jv, kv, dv, mm, bsy, qff, qfb;
   logic [2:0] stuck = 3'b100;
   logic [7:0] ec_a, ec_b;
   logic [1:0] ec_c;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit checks_on = 0;

   always #5 clk = ~clk;

   jk_seq_driver #(.DEPTH(4), .USE_TOGGLE(0), .INIT_CYC(1), .ERR_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
      .tgt_ready(rdy[0]), .J(jv[0]), .K(kv[0]), .q_fb(qfb[0]),
      .drv_valid(dv[0]), .mismatch(mm[0]), .err_cnt(ec_a), .busy(bsy[0]));

   jk_seq_driver #(.DEPTH(4), .USE_TOGGLE(1), .INIT_CYC(1), .ERR_W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
      .tgt_ready(rdy[1]), .J(jv[1]), .K(kv[1]), .q_fb(qfb[1]),
      .drv_valid(dv[1]), .mismatch(mm[1]), .err_cnt(ec_b), .busy(bsy[1]));

   jk_seq_driver #(.DEPTH(4), .USE_TOGGLE(0), .INIT_CYC(1), .ERR_W(2)) u_c (
      .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
      .tgt_ready(rdy[2]), .J(jv[2]), .K(kv[2]), .q_fb(qfb[2]),
      .drv_valid(dv[2]), .mismatch(mm[2]), .err_cnt(ec_c), .busy(bsy[2]));

   // Real jk_ff behaviour for each instance; a stuck flag forces feedback to 0.
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) qff[i] <= 1'b0;
         else if (jv[i] && kv[i]) qff[i] <= ~qff[i];
         else if (jv[i]) qff[i] <= 1'b1;
         else if (kv[i]) qff[i] <= 1'b0;
      end
   end
   assign qfb = qff & ~stuck;

   function automatic int ecv(int i);
      if (i == 0) return int'(ec_a);
      if (i == 1) return int'(ec_b);
      return int'(ec_c);
   endfunction

   // Behavioural model: FIFO as a queue, checks as (due cycle, expected) pairs.
   int  emax[3] = '{255, 255, 3};
   bit  tg[3]   = '{0, 1, 0};
   bit  fq[3][$];
   int  cdue[3][$];
   bit  cexp[3][$];
   bit  mqm[3], mJ[3], mK[3], mDV[3], mMM[3];
   int  merr[3], mi[3];

   task automatic mreset(int i);
      fq[i].delete(); cdue[i].delete(); cexp[i].delete();
      mqm[i] = 0; mJ[i] = 0; mK[i] = 1; mDV[i] = 0; mMM[i] = 0;
      merr[i] = 0; mi[i] = 1;
   endtask

   task automatic mstep(int i);
      bit d, acc;
      if (cdue[i].size() != 0 && cdue[i][0] == cyc) begin
         mMM[i] = (qfb[i] != cexp[i][0]);
         if (mMM[i] && merr[i] < emax[i]) merr[i]++;
         void'(cdue[i].pop_front());
         void'(cexp[i].pop_front());
      end else begin
         mMM[i] = 0;
      end
      if (mi[i] > 0) begin
         mJ[i] = 0; mK[i] = 1; mDV[i] = 0;
         mi[i]--;
         if (mi[i] == 0) begin cdue[i].push_back(cyc + 2); cexp[i].push_back(0); end
      end else begin
         acc = tgt_valid && (fq[i].size() != 4);
         if (fq[i].size() != 0) begin
            d = fq[i].pop_front();
            if (d == mqm[i]) begin mJ[i] = 0; mK[i] = 0; end
            else if (tg[i]) begin mJ[i] = 1; mK[i] = 1; end
            else begin mJ[i] = d; mK[i] = !d; end
            mqm[i] = d; mDV[i] = 1;
            cdue[i].push_back(cyc + 2); cexp[i].push_back(d);
         end else begin
            mJ[i] = 0; mK[i] = 0; mDV[i] = 0;
         end
         if (acc) fq[i].push_back(tgt_bit);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) mreset(i);
         else mstep(i);
      end
   end

   always @(negedge rst_n) begin
      for (int i = 0; i < 3; i++) mreset(i);
   end

   task automatic cmp(string name, int i, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d] cyc=%0d got=%0d want=%0d", name, i, cyc, act, exp);
      end
   endtask

   int jk_log[3][$];
   int mm_cyc[$];
   int acc_cyc[$];

   always @(negedge clk) begin
      if (checks_on) begin
         for (int i = 0; i < 3; i++) begin
            cmp("J", i, int'(jv[i]), int'(mJ[i]));
            cmp("K", i, int'(kv[i]), int'(mK[i]));
            cmp("drv_valid", i, int'(dv[i]), int'(mDV[i]));
            cmp("mismatch", i, int'(mm[i]), int'(mMM[i]));
            cmp("err_cnt", i, ecv(i), merr[i]);
            cmp("tgt_ready", i, int'(rdy[i]), int'(mi[i] == 0 && fq[i].size() != 4));
            cmp("busy", i, int'(bsy[i]),
                int'(mi[i] != 0 || fq[i].size() != 0 || cdue[i].size() != 0));
            if (dv[i]) jk_log[i].push_back({30'd0, jv[i], kv[i]});
         end
         if (mm[0]) mm_cyc.push_back(cyc);
      end
   end

   task automatic push(input bit b);
      bit done = 0;
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_bit   = b;
      for (int n = 0; n < 20 && !done; n++) begin
         @(posedge clk);
         if (rdy[0]) done = 1;
      end
      #1;
      if (done) acc_cyc.push_back(cyc);
      else cmp("push_timeout", 0, 0, 1);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      tgt_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      for (int i = 0; i < 3; i++) jk_log[i].delete();
      mm_cyc.delete();
      acc_cyc.delete();
   endtask

   task automatic chk_log(string name, int i, int exp[]);
      cmp({name, "_len"}, i, jk_log[i].size(), exp.size());
      for (int k = 0; k < exp.size() && k < jk_log[i].size(); k++)
         cmp(name, i, jk_log[i][k], exp[k]);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 checks_on = 1;
      idle(2);

      // T1: reset mid-stream flushes queued targets
      push(1); push(1); push(1);
      @(negedge clk);
      tgt_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      cmp("rst_J", 0, int'(jv[0]), 0);
      cmp("rst_K", 0, int'(kv[0]), 1);
      cmp("rst_err", 2, ecv(2), 0);
      cmp("rst_ready", 0, int'(rdy[0]), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cmp("post_rst_ready", 0, int'(rdy[0]), 1);
      cmp("post_rst_drv_valid", 0, int'(dv[0]), 0);
      idle(4);
      cmp("flushed_busy", 0, int'(bsy[0]), 0);

      // T3: toggle mode from Q=0
      clear_logs();
      push(1); push(0); push(1);
      idle(6);
      chk_log("t3_jk", 1, '{3, 3, 3});
      cmp("t3_err", 1, ecv(1), 0);
      push(0);
      idle(6);

      // T2: set/reset excitation from Q=0
      clear_logs();
      push(1); push(1); push(0); push(0); push(1);
      idle(6);
      chk_log("t2_jk", 0, '{2, 0, 1, 0, 2});
      cmp("t2_err", 0, ecv(0), 0);
      cmp("t2_mm_pulses", 0, mm_cyc.size(), 0);

      // T4: six back-to-back targets, then idle hold
      clear_logs();
      push(1); push(0); push(1); push(1); push(0); push(1);
      idle(6);
      cmp("t4_dv_cycles", 0, jk_log[0].size(), 6);
      cmp("t4_hold_J", 0, int'(jv[0]), 0);
      cmp("t4_hold_K", 0, int'(kv[0]), 0);
      cmp("t4_hold_dv", 0, int'(dv[0]), 0);

      // T5: stuck feedback on instance A
      clear_logs();
      @(negedge clk);
      stuck[0] = 1'b1;
      push(1); push(1); push(1);
      idle(6);
      cmp("t5_err", 0, ecv(0), 3);
      cmp("t5_pulses", 0, mm_cyc.size(), 3);
      for (int k = 0; k < 3 && k < mm_cyc.size() && k < acc_cyc.size(); k++)
         cmp("t5_latency", 0, mm_cyc[k] - acc_cyc[k], 3);

      // T6: narrow counter saturates
      push(1); push(1); push(1); push(1); push(1);
      idle(6);
      cmp("t6_sat", 2, ecv(2), 3);

      checks_on = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1);
   end

endmodule
